// File: rtl/io_bus_pkg.sv
// io_bus_pkg -- shared definitions for the two-port IO bus arbiter.
//   state_e      : sequencer states (IDLE / XFER / GAP / ERR)
//   PORT0/PORT1  : requester indices (0 = CPU router, 1 = DMA / peripheral)
//   ERR_RDATA    : read data returned for an out-of-window access
//   DEF_IO_*     : default IO window bounds (inclusive)
//   in_window()  : unsigned, inclusive address window compare
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [7:0]  ERR_RDATA    = 8'hFF;
  localparam logic [15:0] DEF_IO_BASE  = 16'hFF00;
  localparam logic [15:0] DEF_IO_LIMIT = 16'hFF7F;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/io_rr_arbiter_2.sv
// io_rr_arbiter_2 -- two-way request picker with a registered last-grant
// pointer. With both requests high the port not granted last wins; the
// pointer favours port 0 out of reset. P_FIXED_PRIORITY = 1 bypasses the
// pointer and always prefers port 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : candidate requests, bit i = port i
//   accept     : the pick is taken this cycle (advances the pointer)
//   gnt_valid  : at least one candidate
//   gnt_idx    : index of the winning port
module io_rr_arbiter_2
  import io_bus_pkg::*;
#(
  parameter bit P_FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Port favoured when both request.
  logic ptr_q, ptr_d;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first where needed), otherwise synthesis infers a latch.
  always_comb begin
    gnt_valid = |req;
    if (P_FIXED_PRIORITY) begin
      gnt_idx = req[0] ? PORT0 : PORT1;
    end else if (&req) begin
      gnt_idx = ptr_q;
    end else begin
      gnt_idx = req[0] ? PORT0 : PORT1;
    end
    // After a grant the other port becomes the favourite.
    ptr_d = accept ? ~gnt_idx : ptr_q;
  end

  // NOTE: clocked state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PORT0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter -- shares the IO bus between two requesters and turns each
// accepted request into a single-cycle, registered bus strobe. Read data is
// captured on the edge that closes the strobe, so reset-on-read registers are
// sampled once. Out-of-window requests complete with ERR and never touch the
// bus.
//   I_CLK, I_ASYNC_RESET_L : clock, asynchronous active-low reset
//   I_REQx/I_WEx/I_ADDRx/I_WDATAx : port x request (held until O_DONEx)
//   O_RDATAx/O_DONEx/O_ERRx       : port x completion (DONE is one cycle)
//   O_GNT                         : one-hot owner during XFER
//   O_ADDR_BUS/O_WE_BUS_L/O_RE_BUS_L/IO_DATA_BUS : IO bus
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter logic [15:0] P_IO_BASE        = DEF_IO_BASE,
  parameter logic [15:0] P_IO_LIMIT       = DEF_IO_LIMIT,
  parameter int unsigned P_GAP_CYCLES     = 0,
  parameter bit          P_FIXED_PRIORITY = 1'b0
) (
  input  logic        I_CLK,
  input  logic        I_ASYNC_RESET_L,
  input  logic        I_REQ0,
  input  logic        I_REQ1,
  input  logic        I_WE0,
  input  logic        I_WE1,
  input  logic [15:0] I_ADDR0,
  input  logic [15:0] I_ADDR1,
  input  logic [7:0]  I_WDATA0,
  input  logic [7:0]  I_WDATA1,
  output logic [7:0]  O_RDATA0,
  output logic [7:0]  O_RDATA1,
  output logic        O_DONE0,
  output logic        O_DONE1,
  output logic        O_ERR0,
  output logic        O_ERR1,
  output logic [1:0]  O_GNT,
  output logic [15:0] O_ADDR_BUS,
  output logic        O_WE_BUS_L,
  output logic        O_RE_BUS_L,
  inout  wire  [7:0]  IO_DATA_BUS
);

  localparam logic [1:0] GAP_LD = 2'(P_GAP_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       gap_cnt_q, gap_cnt_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [1:0][7:0]  rdata_q, rdata_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             we_l_q, we_l_d;
  logic             re_l_q, re_l_d;
  logic             drive_q, drive_d;

  logic        pick_valid, pick_idx, accept, sel_we, sel_in_win;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [1:0]  cand;

  // A port completing this cycle still shows REQ high; mask it so the same
  // request is not accepted twice.
  assign cand   = {I_REQ1 & ~done_q[1], I_REQ0 & ~done_q[0]};
  assign accept = (state_q == ST_IDLE) && pick_valid;

  io_rr_arbiter_2 #(.P_FIXED_PRIORITY(P_FIXED_PRIORITY)) u_arb (
    .clk       (I_CLK),
    .rst_n     (I_ASYNC_RESET_L),
    .req       (cand),
    .accept    (accept),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign sel_we     = pick_idx ? I_WE1    : I_WE0;
  assign sel_addr   = pick_idx ? I_ADDR1  : I_ADDR0;
  assign sel_wdata  = pick_idx ? I_WDATA1 : I_WDATA0;
  assign sel_in_win = in_window(sel_addr, P_IO_BASE, P_IO_LIMIT);

  // State register.
  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_L) begin
    if (!I_ASYNC_RESET_L) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = sel_in_win ? ST_XFER : ST_ERR;
      ST_XFER: begin
        if (GAP_LD != 2'd0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 2'd1) state_d = ST_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 2'd1;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. Bus strobes are computed one cycle ahead and
  // registered, so they are glitch-free and valid for the whole XFER cycle.
  always_comb begin
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    gnt_d   = 2'b00;
    we_l_d  = 1'b1;
    re_l_d  = 1'b1;
    drive_d = 1'b0;

    if (accept) begin
      port_d  = pick_idx;
      we_d    = sel_we;
      wdata_d = sel_wdata;
      if (sel_in_win) begin
        // The bus address only moves for real transfers; it holds otherwise.
        addr_d  = sel_addr;
        gnt_d   = (pick_idx == PORT1) ? 2'b10 : 2'b01;
        we_l_d  = ~sel_we;
        re_l_d  = sel_we;
        drive_d = sel_we;
      end
    end

    if (state_q == ST_XFER) begin
      done_d[port_q] = 1'b1;
      if (!we_q) rdata_d[port_q] = IO_DATA_BUS;
    end

    if (state_q == ST_ERR) begin
      done_d[port_q]  = 1'b1;
      err_d[port_q]   = 1'b1;
      rdata_d[port_q] = ERR_RDATA;
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_L) begin
    if (!I_ASYNC_RESET_L) begin
      port_q  <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rdata_q <= '0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      gnt_q   <= 2'b00;
      we_l_q  <= 1'b1;
      re_l_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      we_l_q  <= we_l_d;
      re_l_q  <= re_l_d;
      drive_q <= drive_d;
    end
  end

  assign O_RDATA0    = rdata_q[0];
  assign O_RDATA1    = rdata_q[1];
  assign O_DONE0     = done_q[0];
  assign O_DONE1     = done_q[1];
  assign O_ERR0      = err_q[0];
  assign O_ERR1      = err_q[1];
  assign O_GNT       = gnt_q;
  assign O_ADDR_BUS  = addr_q;
  assign O_WE_BUS_L  = we_l_q;
  assign O_RE_BUS_L  = re_l_q;
  // Reset clears drive_q asynchronously, releasing the bus at once.
  assign IO_DATA_BUS = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter. Three instances share the request
// inputs: u_a (round-robin, no gap), u_b (fixed priority), u_c (2 gap cycles).
// Each has its own data bus, answered by a simple memory model that drives
// rd_val while that instance's read strobe is low.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, rd_val;
  int          tests = 0;
  int          failed = 0;

  logic [7:0]  a_rdata0, a_rdata1, b_rdata0, b_rdata1, c_rdata0, c_rdata1;
  logic        a_done0, a_done1, b_done0, b_done1, c_done0, c_done1;
  logic        a_err0, a_err1, b_err0, b_err1, c_err0, c_err1;
  logic [1:0]  a_gnt, b_gnt, c_gnt;
  logic [15:0] a_addr, b_addr, c_addr;
  logic        a_we_l, a_re_l, b_we_l, b_re_l, c_we_l, c_re_l;
  wire  [7:0]  a_bus, b_bus, c_bus;

  assign a_bus = a_re_l ? 8'hzz : rd_val;
  assign b_bus = b_re_l ? 8'hzz : rd_val;
  assign c_bus = c_re_l ? 8'hzz : rd_val;

  always #5 clk = ~clk;

  io_bus_arbiter u_a (
    .I_CLK(clk), .I_ASYNC_RESET_L(rst_n),
    .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_ADDR0(addr0), .I_ADDR1(addr1), .I_WDATA0(wdata0), .I_WDATA1(wdata1),
    .O_RDATA0(a_rdata0), .O_RDATA1(a_rdata1), .O_DONE0(a_done0), .O_DONE1(a_done1),
    .O_ERR0(a_err0), .O_ERR1(a_err1), .O_GNT(a_gnt), .O_ADDR_BUS(a_addr),
    .O_WE_BUS_L(a_we_l), .O_RE_BUS_L(a_re_l), .IO_DATA_BUS(a_bus)
  );

  io_bus_arbiter #(.P_FIXED_PRIORITY(1'b1)) u_b (
    .I_CLK(clk), .I_ASYNC_RESET_L(rst_n),
    .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_ADDR0(addr0), .I_ADDR1(addr1), .I_WDATA0(wdata0), .I_WDATA1(wdata1),
    .O_RDATA0(b_rdata0), .O_RDATA1(b_rdata1), .O_DONE0(b_done0), .O_DONE1(b_done1),
    .O_ERR0(b_err0), .O_ERR1(b_err1), .O_GNT(b_gnt), .O_ADDR_BUS(b_addr),
    .O_WE_BUS_L(b_we_l), .O_RE_BUS_L(b_re_l), .IO_DATA_BUS(b_bus)
  );

  io_bus_arbiter #(.P_GAP_CYCLES(2)) u_c (
    .I_CLK(clk), .I_ASYNC_RESET_L(rst_n),
    .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_ADDR0(addr0), .I_ADDR1(addr1), .I_WDATA0(wdata0), .I_WDATA1(wdata1),
    .O_RDATA0(c_rdata0), .O_RDATA1(c_rdata1), .O_DONE0(c_done0), .O_DONE1(c_done1),
    .O_ERR0(c_err0), .O_ERR1(c_err1), .O_GNT(c_gnt), .O_ADDR_BUS(c_addr),
    .O_WE_BUS_L(c_we_l), .O_RE_BUS_L(c_re_l), .IO_DATA_BUS(c_bus)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0; rd_val = 8'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0; rd_val = 8'h0;
    @(negedge clk);
    tests++;
    if ({a_we_l, a_re_l, a_gnt, a_done1, a_done0, a_err1, a_err0} !== 8'b1100_0000) begin
      failed++;
      $display("FAIL reset_ctrl: got %b expected 11000000",
               {a_we_l, a_re_l, a_gnt, a_done1, a_done0, a_err1, a_err0});
    end
    tests++;
    if (a_addr !== 16'h0000) begin
      failed++; $display("FAIL reset_addr: got %h expected 0000", a_addr);
    end
    tests++;
    if ({a_rdata1, a_rdata0} !== 16'h0000) begin
      failed++; $display("FAIL reset_rdata: got %h expected 0000", {a_rdata1, a_rdata0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_we_l, a_re_l, a_gnt, a_done1, a_done0} !== 6'b110000) begin
      failed++; $display("FAIL idle_no_req: got %b expected 110000",
                         {a_we_l, a_re_l, a_gnt, a_done1, a_done0});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFF44; rd_val = 8'h91;
    @(negedge clk);  // strobe cycle
    tests++;
    if ({a_re_l, a_we_l, a_gnt, a_done0} !== 5'b0_1_01_0) begin
      failed++; $display("FAIL read_strobe: got %b expected 01010", {a_re_l, a_we_l, a_gnt, a_done0});
    end
    tests++;
    if (a_addr !== 16'hFF44) begin
      failed++; $display("FAIL read_addr: got %h expected ff44", a_addr);
    end
    @(negedge clk);  // DONE cycle
    rd_val = 8'h00;
    tests++;
    if ({a_done0, a_err0, a_re_l, a_gnt} !== 5'b10100) begin
      failed++; $display("FAIL read_done: got %b expected 10100", {a_done0, a_err0, a_re_l, a_gnt});
    end
    tests++;
    if (a_rdata0 !== 8'h91) begin
      failed++; $display("FAIL read_data: got %h expected 91", a_rdata0);
    end
    req0 = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_done0, a_re_l, a_rdata0, a_addr} !== {1'b0, 1'b1, 8'h91, 16'hFF44}) begin
      failed++; $display("FAIL read_hold: got %h expected %h",
                         {a_done0, a_re_l, a_rdata0, a_addr}, {1'b0, 1'b1, 8'h91, 16'hFF44});
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFF40; wdata1 = 8'h3C;
    @(negedge clk);
    tests++;
    if ({a_we_l, a_re_l, a_gnt} !== 4'b0110) begin
      failed++; $display("FAIL write_strobe: got %b expected 0110", {a_we_l, a_re_l, a_gnt});
    end
    tests++;
    if (a_bus !== 8'h3C || a_addr !== 16'hFF40) begin
      failed++; $display("FAIL write_bus: got %h/%h expected 3c/ff40", a_bus, a_addr);
    end
    @(negedge clk);
    tests++;
    if ({a_done1, a_err1, a_done0, a_we_l} !== 4'b1001) begin
      failed++; $display("FAIL write_done: got %b expected 1001", {a_done1, a_err1, a_done0, a_we_l});
    end
    tests++;
    if (a_bus === 8'h3C) begin
      failed++; $display("FAIL write_release: got %h expected not 3c", a_bus);
    end
    req1 = 1'b0;
    @(negedge clk);
    tests++;
    if (a_done1 !== 1'b0) begin
      failed++; $display("FAIL write_done_pulse: got %b expected 0", a_done1);
    end
  endtask

  // Completes one port-0 read, then raises both requests together while
  // idle; returns the first two grants seen on instances a and b.
  task automatic probe_pointer(output logic [1:0] a1, output logic [1:0] a2,
                               output logic [1:0] b1, output logic [1:0] b2);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFF10;
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 16'hFF20;
    @(negedge clk);
    a1 = a_gnt; b1 = b_gnt;
    repeat (2) @(negedge clk);
    a2 = a_gnt; b2 = b_gnt;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_tab [8];
    logic [1:0] g1, g2, h1, h2;
    // {gnt, done1, done0} per cycle after both ports request from reset.
    exp_tab = '{4'b01_00, 4'b00_01, 4'b10_00, 4'b00_10,
                4'b01_00, 4'b00_01, 4'b10_00, 4'b00_10};
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'hFF10; addr1 = 16'hFF20; rd_val = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if ({a_gnt, a_done1, a_done0} !== exp_tab[i]) begin
        failed++; $display("FAIL rr_seq[%0d]: got %b expected %b", i, {a_gnt, a_done1, a_done0}, exp_tab[i]);
      end
      if (i == 6) req0 = 1'b0;
      if (i == 7) req1 = 1'b0;
    end
    @(negedge clk);
    tests++;
    if ({a_gnt, a_done1, a_done0} !== 4'b0000) begin
      failed++; $display("FAIL rr_drain: got %b expected 0000", {a_gnt, a_done1, a_done0});
    end
    do_reset();
    probe_pointer(g1, g2, h1, h2);
    tests++;
    if ({g1, g2} !== 4'b1001) begin
      failed++; $display("FAIL rr_pointer: got %b expected 1001", {g1, g2});
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] g1, g2, h1, h2;
    do_reset();
    probe_pointer(g1, g2, h1, h2);
    tests++;
    if ({h1, h2} !== 4'b0110) begin
      failed++; $display("FAIL fixed_pick: got %b expected 0110", {h1, h2});
    end
  endtask

  task automatic test_window();
    typedef struct packed {
      logic        port;
      logic        we;
      logic [15:0] addr;
      logic        in_win;
    } vec_t;
    vec_t        tab [5];
    logic [15:0] exp_addr;
    logic [1:0]  onehot, exp_err;
    logic [7:0]  got_rd;
    tab = '{'{1'b0, 1'b0, 16'hFF7F, 1'b1},
            '{1'b1, 1'b1, 16'hFF00, 1'b1},
            '{1'b0, 1'b0, 16'hFF80, 1'b0},
            '{1'b1, 1'b0, 16'h8000, 1'b0},
            '{1'b0, 1'b0, 16'hFEFF, 1'b0}};
    do_reset();
    exp_addr = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      onehot = tab[i].port ? 2'b10 : 2'b01;
      rd_val = 8'hC0 + 8'(i);
      if (tab[i].port) begin
        req1 = 1'b1; we1 = tab[i].we; addr1 = tab[i].addr; wdata1 = 8'h77;
      end else begin
        req0 = 1'b1; we0 = tab[i].we; addr0 = tab[i].addr;
      end
      if (tab[i].in_win) exp_addr = tab[i].addr;
      @(negedge clk);
      tests++;
      if ({a_we_l, a_re_l, a_gnt, a_addr} !==
          {tab[i].in_win ? {~tab[i].we, tab[i].we, onehot} : 4'b1100, exp_addr}) begin
        failed++; $display("FAIL window_bus[%0d]: got %b/%h expected in_win=%b addr %h",
                           i, {a_we_l, a_re_l, a_gnt}, a_addr, tab[i].in_win, exp_addr);
      end
      @(negedge clk);
      exp_err = tab[i].in_win ? 2'b00 : onehot;
      tests++;
      if ({a_done1, a_done0, a_err1, a_err0} !== {onehot, exp_err}) begin
        failed++; $display("FAIL window_done[%0d]: got %b expected %b",
                           i, {a_done1, a_done0, a_err1, a_err0}, {onehot, exp_err});
      end
      if (!tab[i].we) begin
        got_rd = tab[i].port ? a_rdata1 : a_rdata0;
        tests++;
        if (got_rd !== (tab[i].in_win ? rd_val : 8'hFF)) begin
          failed++; $display("FAIL window_rdata[%0d]: got %h expected %h",
                             i, got_rd, tab[i].in_win ? rd_val : 8'hFF);
        end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    logic exp_re, exp_done;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFF44; rd_val = 8'h2B;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_re   = !(i == 1 || i == 5 || i == 9);
      exp_done = (i == 2 || i == 6 || i == 10);
      tests++;
      if ({c_re_l, c_we_l, c_done0} !== {exp_re, 1'b1, exp_done}) begin
        failed++; $display("FAIL gap[%0d]: got %b expected %b", i, {c_re_l, c_we_l, c_done0},
                           {exp_re, 1'b1, exp_done});
      end
      if (i == 9) req0 = 1'b0;
    end
    tests++;
    if (c_rdata0 !== 8'h2B) begin
      failed++; $display("FAIL gap_rdata: got %h expected 2b", c_rdata0);
    end
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFF40; wdata1 = 8'h5A;
    @(negedge clk);
    tests++;
    if (a_we_l !== 1'b0) begin
      failed++; $display("FAIL midrst_pre: got %b expected 0", a_we_l);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({a_we_l, a_re_l, a_gnt} !== 4'b1100 || a_bus === 8'h5A) begin
      failed++; $display("FAIL midrst_release: got %b/%h expected 1100/not 5a",
                         {a_we_l, a_re_l, a_gnt}, a_bus);
    end
    @(negedge clk);
    tests++;
    if (a_done1 !== 1'b0) begin
      failed++; $display("FAIL midrst_no_done: got %b expected 0", a_done1);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFF00;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_gnt, a_done1} !== 3'b010) begin
      failed++; $display("FAIL midrst_first_grant: got %b expected 010", {a_gnt, a_done1});
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_window();
    test_gap();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
